// File: rtl/scan_dac_scheduler_pkg.sv
// scan_dac_pkg: shared types and constants for the HV DAC scan scheduler.
//   state_t        scheduler FSM states
//   CMD_A..CMD_D   SPI command bytes per DAC channel (CMD_D also latches all outputs)
//   INIT_W0..W3    one-time DAC init frames sent after reset
//   scan constants step size, raster extents, start codes, laser pulse width
//   build_frame()  assembles {cmd, code} for a channel index
//   init_word()    selects the init frame for an index
package scan_dac_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_SEND  = 3'd2,
      ST_HOST  = 3'd3,
      ST_WAIT  = 3'd4,
      ST_PULSE = 3'd5,
      ST_ADV   = 3'd6
   } state_t;

   localparam logic [7:0]  CMD_A   = 8'h00;
   localparam logic [7:0]  CMD_B   = 8'h01;
   localparam logic [7:0]  CMD_C   = 8'h02;
   localparam logic [7:0]  CMD_D   = 8'h13;

   localparam logic [23:0] INIT_W0 = 24'h290001;
   localparam logic [23:0] INIT_W1 = 24'h390001;
   localparam logic [23:0] INIT_W2 = 24'h20000F;
   localparam logic [23:0] INIT_W3 = 24'h300000;

   localparam logic [15:0] STEP      = 16'h04D0;
   localparam logic [5:0]  H_STEPS   = 6'd40;
   localparam logic [5:0]  V_STEPS   = 6'd40;
   localparam logic [15:0] XP0       = 16'h0DB9;
   localparam logic [15:0] XM0       = 16'hCE3C;
   localparam logic [15:0] YM0       = 16'h0DB9;
   localparam logic [15:0] YP0       = 16'hCE3C;
   localparam logic [3:0]  PULSE_CYC = 4'd8;

   function automatic logic [23:0] build_frame(input logic [1:0] ch, input logic [15:0] code);
      logic [7:0] cmd;
      case (ch)
         2'd0:    cmd = CMD_A;
         2'd1:    cmd = CMD_B;
         2'd2:    cmd = CMD_C;
         default: cmd = CMD_D;
      endcase
      return {cmd, code};
   endfunction

   function automatic logic [23:0] init_word(input logic [1:0] idx);
      logic [23:0] w;
      case (idx)
         2'd0:    w = INIT_W0;
         2'd1:    w = INIT_W1;
         2'd2:    w = INIT_W2;
         default: w = INIT_W3;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/scan_dac_scheduler_scan_pos_gen.sv
// scan_pos_gen: serpentine raster position and DAC channel codes.
//   fpgaclock, rst   clock, async active-low reset
//   adv              one-cycle strobe: step to the next scan point
//   code_a..code_d   current X+/X-/Y-/Y+ DAC codes
//   last_point       current point is the last of the frame
module scan_pos_gen
   import scan_dac_pkg::*;
(
   input  logic        fpgaclock,
   input  logic        rst,
   input  logic        adv,
   output logic [15:0] code_a,
   output logic [15:0] code_b,
   output logic [15:0] code_c,
   output logic [15:0] code_d,
   output logic        last_point
);

   logic [5:0]  h_q, h_d, v_q, v_d;
   logic        dir_q, dir_d;
   logic [15:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

   assign last_point = (h_q == H_STEPS) && (v_q == V_STEPS);
   assign code_a = a_q;
   assign code_b = b_q;
   assign code_c = c_q;
   assign code_d = d_q;

   // Next position: X pair steps along the row, Y pair steps at row turns.
   always_comb begin
      h_d = h_q; v_d = v_q; dir_d = dir_q;
      a_d = a_q; b_d = b_q; c_d = c_q; d_d = d_q;
      if (adv) begin
         if (h_q == H_STEPS) begin
            if (v_q == V_STEPS) begin
               // end of frame: back to the raster origin
               h_d = 6'd0; v_d = 6'd0; dir_d = 1'b0;
               a_d = XP0; b_d = XM0; c_d = YM0; d_d = YP0;
            end else begin
               // row turn: X holds, Y pair steps, direction flips
               h_d   = 6'd0;
               v_d   = v_q + 6'd1;
               dir_d = ~dir_q;
               c_d   = c_q + STEP;
               d_d   = d_q - STEP;
            end
         end else begin
            h_d = h_q + 6'd1;
            if (dir_q) begin
               a_d = a_q - STEP;
               b_d = b_q + STEP;
            end else begin
               a_d = a_q + STEP;
               b_d = b_q - STEP;
            end
         end
      end else begin
         h_d = h_q;
         v_d = v_q;
      end
   end

   // Position and code registers.
   always_ff @(posedge fpgaclock or negedge rst) begin
      if (!rst) begin
         h_q <= 6'd0; v_q <= 6'd0; dir_q <= 1'b0;
         a_q <= XP0; b_q <= XM0; c_q <= YM0; d_q <= YP0;
      end else begin
         h_q <= h_d; v_q <= v_d; dir_q <= dir_d;
         a_q <= a_d; b_q <= b_d; c_q <= c_d; d_q <= d_d;
      end
   end

endmodule

// File: rtl/scan_dac_scheduler.sv
// scan_dac_scheduler: sequences every frame to the 4-channel HV DAC shifter.
//   fpgaclock, rst      clock, async active-low reset
//   enable              scan run request (level)
//   host_req/host_word  host frame request, held until host_ack
//   host_ack            one-cycle pulse once the host frame has shifted out
//   spi_start/spi_word  frame launch to the shifter, word held until spi_done
//   spi_done            shifter completion pulse
//   pulse_out           laser drive, PULSE_CYC cycles per scan point
//   frame_done          one-cycle pulse after the last point of a frame
//   busy                scheduler is not idle
module scan_dac_scheduler
   import scan_dac_pkg::*;
(
   input  logic        fpgaclock,
   input  logic        rst,
   input  logic        enable,
   input  logic        host_req,
   input  logic [23:0] host_word,
   output logic        host_ack,
   output logic        spi_start,
   output logic [23:0] spi_word,
   input  logic        spi_done,
   output logic        pulse_out,
   output logic        frame_done,
   output logic        busy
);

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        init_done_q, init_done_d;
   logic        host_q, host_d;
   logic        spi_start_q, spi_start_d;
   logic [23:0] spi_word_q, spi_word_d;
   logic        pulse_q, pulse_d;
   logic        frame_done_q, frame_done_d;
   logic        host_ack_q, host_ack_d;
   logic        busy_q, busy_d;

   logic        adv_s, last_point_s;
   logic [15:0] code_a_s, code_b_s, code_c_s, code_d_s, code_sel_s;

   assign adv_s = (state_q == ST_ADV);

   scan_pos_gen u_pos (
      .fpgaclock  (fpgaclock),
      .rst        (rst),
      .adv        (adv_s),
      .code_a     (code_a_s),
      .code_b     (code_b_s),
      .code_c     (code_c_s),
      .code_d     (code_d_s),
      .last_point (last_point_s)
   );

   // Channel code for the frame currently being built.
   always_comb begin
      case (idx_q)
         2'd0:    code_sel_s = code_a_s;
         2'd1:    code_sel_s = code_b_s;
         2'd2:    code_sel_s = code_c_s;
         default: code_sel_s = code_d_s;
      endcase
   end

   // Scheduler next-state and next-output logic.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      init_done_d  = init_done_q;
      host_d       = host_q;
      spi_start_d  = 1'b0;
      spi_word_d   = spi_word_q;
      pulse_d      = 1'b0;
      frame_done_d = 1'b0;
      host_ack_d   = 1'b0;
      case (state_q)
         ST_INIT: begin
            spi_start_d = 1'b1;
            spi_word_d  = init_word(idx_q);
            state_d     = ST_WAIT;
         end
         ST_IDLE: begin
            // host_ack_q masks the request still held in the ack cycle
            if (host_req && !host_ack_q) begin
               state_d = ST_HOST;
            end else if (enable) begin
               idx_d   = 2'd0;
               state_d = ST_SEND;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            spi_start_d = 1'b1;
            spi_word_d  = build_frame(idx_q, code_sel_s);
            state_d     = ST_WAIT;
         end
         ST_HOST: begin
            spi_start_d = 1'b1;
            spi_word_d  = host_word;
            host_d      = 1'b1;
            state_d     = ST_WAIT;
         end
         ST_WAIT: begin
            // a done coincident with our own launch cannot belong to this frame
            if (spi_done && !spi_start_q) begin
               if (!init_done_q) begin
                  if (idx_q == 2'd3) begin
                     init_done_d = 1'b1;
                     idx_d       = 2'd0;
                     state_d     = ST_IDLE;
                  end else begin
                     idx_d   = idx_q + 2'd1;
                     state_d = ST_INIT;
                  end
               end else if (host_q) begin
                  host_d     = 1'b0;
                  host_ack_d = 1'b1;
                  state_d    = ST_IDLE;
               end else if (idx_q == 2'd3) begin
                  idx_d   = 2'd0;
                  cnt_d   = 4'd0;
                  pulse_d = 1'b1;
                  state_d = ST_PULSE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = ST_SEND;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_PULSE: begin
            if (cnt_q == (PULSE_CYC - 4'd1)) begin
               state_d = ST_ADV;
            end else begin
               cnt_d   = cnt_q + 4'd1;
               pulse_d = 1'b1;
            end
         end
         ST_ADV: begin
            frame_done_d = last_point_s;
            state_d      = ST_IDLE;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and registered outputs.
   always_ff @(posedge fpgaclock or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_INIT;
         idx_q        <= 2'd0;
         cnt_q        <= 4'd0;
         init_done_q  <= 1'b0;
         host_q       <= 1'b0;
         spi_start_q  <= 1'b0;
         spi_word_q   <= 24'd0;
         pulse_q      <= 1'b0;
         frame_done_q <= 1'b0;
         host_ack_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         init_done_q  <= init_done_d;
         host_q       <= host_d;
         spi_start_q  <= spi_start_d;
         spi_word_q   <= spi_word_d;
         pulse_q      <= pulse_d;
         frame_done_q <= frame_done_d;
         host_ack_q   <= host_ack_d;
         busy_q       <= busy_d;
      end
   end

   assign spi_start  = spi_start_q;
   assign spi_word   = spi_word_q;
   assign pulse_out  = pulse_q;
   assign frame_done = frame_done_q;
   assign host_ack   = host_ack_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_scan_dac_scheduler.sv
// Self-checking bench for scan_dac_scheduler: a shifter model logs every
// launched frame; scan frames are compared against a closed-form raster model.
module tb_scan_dac_scheduler;

   logic        fpgaclock = 1'b0;
   logic        rst, enable, host_req, spi_done;
   logic [23:0] host_word;
   logic        host_ack, spi_start, pulse_out, frame_done, busy;
   logic [23:0] spi_word;

   int passed = 0, total = 0;
   int rd = 0, pt = 0;
   int pulses = 0, bad_pulse = 0, fd_cnt = 0, ack_cnt = 0, run = 0;
   int viol = 0, hold_err = 0, cnt = 0;
   bit pending = 1'b0, lat_rand = 1'b0, stray_req = 1'b0;
   logic [23:0] cur;
   logic [23:0] wlog[$];
   logic [23:0] init_tab[4] = '{24'h290001, 24'h390001, 24'h20000F, 24'h300000};

   always #10 fpgaclock = ~fpgaclock;

   scan_dac_scheduler dut (
      .fpgaclock  (fpgaclock),
      .rst        (rst),
      .enable     (enable),
      .host_req   (host_req),
      .host_word  (host_word),
      .host_ack   (host_ack),
      .spi_start  (spi_start),
      .spi_word   (spi_word),
      .spi_done   (spi_done),
      .pulse_out  (pulse_out),
      .frame_done (frame_done),
      .busy       (busy)
   );

   // Expected frame for scan point p (counted from the first point after init).
   function automatic logic [23:0] exp_word(input int p, input int ch);
      int q, row, col, x;
      logic [15:0] code;
      q   = p % 1681;
      row = q / 41;
      col = q % 41;
      x   = (row % 2 == 1) ? 40 - col : col;
      case (ch)
         0:       return {8'h00, 16'(32'h0DB9 + x * 32'h04D0)};
         1:       return {8'h01, 16'(32'hCE3C - x * 32'h04D0)};
         2:       return {8'h02, 16'(32'h0DB9 + row * 32'h04D0)};
         default: begin
            code = 16'(32'hCE3C - row * 32'h04D0);
            return {8'h13, code};
         end
      endcase
   endfunction

   // Shifter model: logs launches, acks after a latency, counts protocol errors.
   initial begin
      spi_done = 1'b0;
      forever begin
         @(negedge fpgaclock);
         if (rst !== 1'b1) begin
            pending  = 1'b0;
            spi_done = stray_req;
         end else if (spi_start === 1'b1) begin
            if (pending) viol++;
            wlog.push_back(spi_word);
            cur      = spi_word;
            pending  = 1'b1;
            cnt      = lat_rand ? int'($urandom_range(1, 3)) : 26;
            spi_done = stray_req;
         end else if (pending) begin
            if (spi_word !== cur) hold_err++;
            if (cnt <= 1) begin
               spi_done = 1'b1;
               pending  = 1'b0;
            end else begin
               cnt--;
               spi_done = stray_req;
            end
         end else begin
            spi_done = stray_req;
         end
      end
   end

   // Output monitor: laser pulse widths, frame_done and host_ack pulses.
   initial begin
      forever begin
         @(negedge fpgaclock);
         if (pulse_out === 1'b1) begin
            run++;
         end else if (run != 0) begin
            if (run != 8) bad_pulse++;
            pulses++;
            run = 0;
         end
         if (frame_done === 1'b1) fd_cnt++;
         if (host_ack === 1'b1) ack_cnt++;
      end
   end

   task automatic test_reset;
      repeat (3) @(negedge fpgaclock);
      total++; if (spi_start !== 1'b0) $display("FAIL reset_spi_start got %b want 0", spi_start); else passed++;
      total++; if (spi_word !== 24'd0) $display("FAIL reset_spi_word got %h want 000000", spi_word); else passed++;
      total++; if (pulse_out !== 1'b0) $display("FAIL reset_pulse got %b want 0", pulse_out); else passed++;
      total++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else passed++;
      total++; if (host_ack !== 1'b0) $display("FAIL reset_host_ack got %b want 0", host_ack); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
   endtask

   task automatic test_init;
      int n = 0;
      rst = 1'b1;
      while (!(wlog.size() == 4 && busy === 1'b0 && !pending) && n < 600) begin
         @(negedge fpgaclock); n++;
      end
      total++; if (n >= 600) $display("FAIL init_timeout got words=%0d want 4", wlog.size()); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wlog.size() <= i || wlog[i] !== init_tab[i]) $display("FAIL init_word%0d got %h want %h", i, (wlog.size() > i) ? wlog[i] : 24'hx, init_tab[i]);
         else passed++;
      end
      total++; if (busy !== 1'b0) $display("FAIL init_busy got %b want 0", busy); else passed++;
      rd = 4;
   endtask

   task automatic test_first_point;
      int n = 0;
      lat_rand = 1'b1;
      enable   = 1'b1;
      while (pulses < 2 && n < 600) begin @(negedge fpgaclock); n++; end
      total++; if (n >= 600) $display("FAIL first_point_timeout got points=%0d want 2", pulses); else passed++;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (wlog.size() <= rd || wlog[rd] !== exp_word(0, c)) $display("FAIL first_point ch=%0d got %h want %h", c, (wlog.size() > rd) ? wlog[rd] : 24'hx, exp_word(0, c));
         else passed++;
         rd++;
      end
      pt = 1;
      total++; if (wlog.size() <= rd || wlog[rd] !== 24'h001289) $display("FAIL second_point_a got %h want 001289", (wlog.size() > rd) ? wlog[rd] : 24'hx); else passed++;
      total++; if (bad_pulse !== 0) $display("FAIL pulse_width got %0d bad pulses want 0", bad_pulse); else passed++;
   endtask

   task automatic test_row_turn;
      int n = 0;
      while (pulses < 42 && n < 4000) begin @(negedge fpgaclock); n++; end
      total++; if (n >= 4000) $display("FAIL row_turn_timeout got points=%0d want 42", pulses); else passed++;
      for (int p = 1; p <= 41; p++) begin
         for (int c = 0; c < 4; c++) begin
            total++;
            if (wlog.size() <= rd || wlog[rd] !== exp_word(p, c)) $display("FAIL row_scan pt=%0d ch=%0d got %h want %h", p, c, (wlog.size() > rd) ? wlog[rd] : 24'hx, exp_word(p, c));
            else passed++;
            rd++;
         end
      end
      pt = 42;
      total++; if (wlog[rd-4] !== 24'h00CE39) $display("FAIL turn_a got %h want 00CE39", wlog[rd-4]); else passed++;
      total++; if (wlog[rd-3] !== 24'h010DBC) $display("FAIL turn_b got %h want 010DBC", wlog[rd-3]); else passed++;
      total++; if (wlog[rd-2] !== 24'h021289) $display("FAIL turn_c got %h want 021289", wlog[rd-2]); else passed++;
      total++; if (wlog[rd-1] !== 24'h13C96C) $display("FAIL turn_d got %h want 13C96C", wlog[rd-1]); else passed++;
   endtask

   task automatic test_host;
      int n = 0;
      int p0;
      ack_cnt = 0;
      while (wlog.size() < rd + 2 && n < 400) begin @(negedge fpgaclock); n++; end
      p0 = pulses;
      host_word = 24'h12ABCD;
      host_req  = 1'b1;
      n = 0;
      while (host_ack !== 1'b1 && n < 600) begin @(negedge fpgaclock); n++; end
      total++; if (n >= 600) $display("FAIL host_ack_timeout got no ack want ack"); else passed++;
      total++; if (pulses !== p0 + 1) $display("FAIL host_after_point got points=%0d want %0d", pulses, p0 + 1); else passed++;
      host_req = 1'b0;
      n = 0;
      while (pulses < p0 + 2 && n < 600) begin @(negedge fpgaclock); n++; end
      total++; if (n >= 600) $display("FAIL host_resume_timeout got points=%0d want %0d", pulses, p0 + 2); else passed++;
      for (int k = 0; k < 9; k++) begin
         logic [23:0] e;
         e = (k < 4) ? exp_word(pt, k) : (k == 4) ? 24'h12ABCD : exp_word(pt + 1, k - 5);
         total++;
         if (wlog.size() <= rd || wlog[rd] !== e) $display("FAIL host_seq k=%0d got %h want %h", k, (wlog.size() > rd) ? wlog[rd] : 24'hx, e);
         else passed++;
         rd++;
      end
      pt = pt + 2;
      total++; if (ack_cnt !== 1) $display("FAIL host_ack_count got %0d want 1", ack_cnt); else passed++;
   endtask

   task automatic test_park;
      int n = 0;
      int p0;
      while (wlog.size() < rd + 1 && n < 400) begin @(negedge fpgaclock); n++; end
      enable = 1'b0;
      p0 = pulses;
      repeat (80) @(negedge fpgaclock);
      total++; if (pulses !== p0 + 1) $display("FAIL park_point_done got points=%0d want %0d", pulses, p0 + 1); else passed++;
      total++; if (wlog.size() !== rd + 4) $display("FAIL park_words got %0d want %0d", wlog.size(), rd + 4); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL park_busy got %b want 0", busy); else passed++;
      stray_req = 1'b1;
      repeat (2) @(negedge fpgaclock);
      stray_req = 1'b0;
      repeat (20) @(negedge fpgaclock);
      total++; if (wlog.size() !== rd + 4) $display("FAIL stray_idle_words got %0d want %0d", wlog.size(), rd + 4); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL stray_idle_busy got %b want 0", busy); else passed++;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (wlog[rd] !== exp_word(pt, c)) $display("FAIL park_point ch=%0d got %h want %h", c, wlog[rd], exp_word(pt, c));
         else passed++;
         rd++;
      end
      pt++;
      total++; if (viol !== 0 || hold_err !== 0) $display("FAIL protocol got viol=%0d hold=%0d want 0/0", viol, hold_err); else passed++;
   endtask

   task automatic test_frame_done;
      int n = 0;
      total++; if (fd_cnt !== 0) $display("FAIL early_frame_done got %0d want 0", fd_cnt); else passed++;
      enable = 1'b1;
      while (pulses < 1682 && n < 90000) begin @(negedge fpgaclock); n++; end
      enable = 1'b0;
      total++; if (n >= 90000) $display("FAIL frame_timeout got points=%0d want 1682", pulses); else passed++;
      repeat (40) @(negedge fpgaclock);
      for (int p = pt; p <= 1681; p++) begin
         for (int c = 0; c < 4; c++) begin
            total++;
            if (wlog.size() <= rd || wlog[rd] !== exp_word(p, c)) $display("FAIL frame_scan pt=%0d ch=%0d got %h want %h", p, c, (wlog.size() > rd) ? wlog[rd] : 24'hx, exp_word(p, c));
            else passed++;
            rd++;
         end
      end
      pt = 1682;
      total++; if (fd_cnt !== 1) $display("FAIL frame_done_count got %0d want 1", fd_cnt); else passed++;
      total++; if (wlog[rd-4] !== 24'h000DB9) $display("FAIL wrap_a got %h want 000DB9", wlog[rd-4]); else passed++;
      total++; if (wlog[rd-1] !== 24'h13CE3C) $display("FAIL wrap_d got %h want 13CE3C", wlog[rd-1]); else passed++;
      total++; if (bad_pulse !== 0 || viol !== 0 || hold_err !== 0) $display("FAIL frame_protocol got pulse=%0d viol=%0d hold=%0d want 0", bad_pulse, viol, hold_err); else passed++;
   endtask

   task automatic test_reset_mid_wait;
      int n = 0;
      int base;
      lat_rand = 1'b0;
      enable   = 1'b1;
      while (!pending && n < 200) begin @(negedge fpgaclock); n++; end
      repeat (5) @(negedge fpgaclock);
      rst    = 1'b0;
      enable = 1'b0;
      @(negedge fpgaclock);
      total++; if (spi_start !== 1'b0 || busy !== 1'b0 || spi_word !== 24'd0) $display("FAIL mid_reset_outputs got start=%b busy=%b word=%h want 0/0/000000", spi_start, busy, spi_word); else passed++;
      stray_req = 1'b1;
      @(negedge fpgaclock);
      stray_req = 1'b0;
      repeat (3) @(negedge fpgaclock);
      base = wlog.size();
      rst  = 1'b1;
      n = 0;
      while (!(wlog.size() == base + 4 && busy === 1'b0 && !pending) && n < 600) begin @(negedge fpgaclock); n++; end
      total++; if (n >= 600) $display("FAIL reinit_timeout got words=%0d want %0d", wlog.size(), base + 4); else passed++;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (wlog.size() <= base + i || wlog[base+i] !== init_tab[i]) $display("FAIL reinit_word%0d got %h want %h", i, (wlog.size() > base + i) ? wlog[base+i] : 24'hx, init_tab[i]);
         else passed++;
      end
      base      = wlog.size();
      pulses    = 0;
      lat_rand  = 1'b1;
      enable    = 1'b1;
      n = 0;
      while (pulses < 1 && n < 400) begin @(negedge fpgaclock); n++; end
      enable = 1'b0;
      for (int c = 0; c < 4; c++) begin
         total++;
         if (wlog.size() <= base + c || wlog[base+c] !== exp_word(0, c)) $display("FAIL reset_origin ch=%0d got %h want %h", c, (wlog.size() > base + c) ? wlog[base+c] : 24'hx, exp_word(0, c));
         else passed++;
      end
      total++; if (viol !== 0 || hold_err !== 0) $display("FAIL reset_protocol got viol=%0d hold=%0d want 0/0", viol, hold_err); else passed++;
   endtask

   initial begin
      rst       = 1'b0;
      enable    = 1'b0;
      host_req  = 1'b0;
      host_word = 24'd0;
      test_reset();
      test_init();
      test_first_point();
      test_row_turn();
      test_host();
      test_park();
      test_frame_done();
      test_reset_mid_wait();
      repeat (5) @(negedge fpgaclock);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
